// File: rtl/lcd_pkg.sv
// Shared types for the LCD SPI sequencer: FSM state encoding, the init-entry
// payload and the default panel init table.
package lcd_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_WAIT,
    INIT_SEND,
    INIT_WAIT,
    IDLE,
    SEND,
    WAIT
  } lcd_state_t;

  // One init ROM entry: dc=0 command byte, dc=1 data byte.
  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } init_entry_t;

  localparam int unsigned INIT_TABLE_LEN = 16;
  localparam int unsigned INIT_TABLE_AW  = 4;

  // Default init table. The first three entries form a minimal bring-up
  // (sleep out, display on, one data byte) usable with INIT_LEN=3.
  function automatic init_entry_t default_init_entry(input logic [INIT_TABLE_AW-1:0] idx);
    init_entry_t e;
    e = '0;
    case (idx)
      4'd0:  e = '{dc: 1'b0, data: 8'h11};  // sleep out
      4'd1:  e = '{dc: 1'b0, data: 8'h29};  // display on
      4'd2:  e = '{dc: 1'b1, data: 8'hAA};
      4'd3:  e = '{dc: 1'b0, data: 8'h36};  // memory access control
      4'd4:  e = '{dc: 1'b1, data: 8'h00};
      4'd5:  e = '{dc: 1'b0, data: 8'h3A};  // pixel format
      4'd6:  e = '{dc: 1'b1, data: 8'h55};
      4'd7:  e = '{dc: 1'b0, data: 8'h21};  // inversion on
      4'd8:  e = '{dc: 1'b0, data: 8'h13};  // normal display mode
      4'd9:  e = '{dc: 1'b0, data: 8'h2A};  // column address set
      4'd10: e = '{dc: 1'b1, data: 8'h00};
      4'd11: e = '{dc: 1'b1, data: 8'h00};
      4'd12: e = '{dc: 1'b1, data: 8'h00};
      4'd13: e = '{dc: 1'b1, data: 8'hEF};
      4'd14: e = '{dc: 1'b0, data: 8'h2B};  // row address set
      4'd15: e = '{dc: 1'b1, data: 8'h00};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational init ROM: maps an init index to its {dc, byte} entry.
// Ports: index (0..254), entry_c (unregistered lookup result; zero when
// index is beyond INIT_LEN or the default table).
module lcd_init_rom
  import lcd_pkg::*;
#(
  parameter int unsigned INIT_LEN = 16
) (
  input  logic [7:0]  index,
  output init_entry_t entry_c
);

  // Entries past the stored table read back as a zero command byte (NOP).
  always_comb begin
    entry_c = '0;
    if ((32'(index) < INIT_LEN) && (32'(index) < INIT_TABLE_LEN)) begin
      entry_c = default_init_entry(index[INIT_TABLE_AW-1:0]);
    end
  end

endmodule

// File: rtl/lcd_spi_sequencer.sv
// LCD SPI sequencer: drives the LCD hardware reset, streams the init table to
// an SPI master, then forwards requester bytes one at a time.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   cmd_valid/byte/dc      requester byte offer (dc: 0 command, 1 data)
//   cmd_ready              offer accepted this cycle (combinational)
//   spi_start/spi_data     one-cycle start pulse and byte to the SPI master
//   spi_busy               SPI master is shifting
//   lcd_dc, lcd_rst_n      LCD D/C pin and active-low hardware reset
//   init_done              init sequence finished (sticky until reset)
// INIT_LEN legal range is 1..255.
module lcd_spi_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 1000,
  parameter int unsigned RST_WAIT_CYCLES = 5000,
  parameter int unsigned INIT_LEN        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_dc,
  output logic       cmd_ready,
  output logic       spi_start,
  output logic [7:0] spi_data,
  input  logic       spi_busy,
  output logic       lcd_dc,
  output logic       lcd_rst_n,
  output logic       init_done
);

  localparam int unsigned CNT_MAX   = (RST_HOLD_CYCLES > RST_WAIT_CYCLES) ?
                                      RST_HOLD_CYCLES : RST_WAIT_CYCLES;
  localparam int unsigned CNT_W_RAW = $clog2(CNT_MAX + 1);
  localparam int unsigned CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  lcd_state_t       state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d, cnt_inc_c;
  logic [7:0]       index, index_d;
  logic             spi_start_d;
  logic [7:0]       spi_data_d;
  logic             lcd_dc_d;
  logic             lcd_rst_n_d;
  logic             init_done_d;
  logic             hold_done_c;
  logic             wait_done_c;
  logic             xfer_done_c;
  init_entry_t      rom_entry_c;

  // ROM is addressed by the next index so the entry lands with the start pulse.
  lcd_init_rom #(
    .INIT_LEN (INIT_LEN)
  ) u_init_rom (
    .index   (index_d),
    .entry_c (rom_entry_c)
  );

  assign cmd_ready = (state == IDLE) && !spi_busy && !rst;

  // Saturating delay counter; also serves as the wait-state guard flag.
  assign cnt_inc_c   = (cnt == CNT_SAT) ? cnt : cnt + CNT_W'(1);
  assign hold_done_c = (33'(cnt) + 33'd1) >= 33'(RST_HOLD_CYCLES);
  assign wait_done_c = (33'(cnt) + 33'd1) >= 33'(RST_WAIT_CYCLES);
  // cnt==0 marks the first wait cycle, where spi_busy may not be up yet.
  assign xfer_done_c = (cnt != '0) && !spi_busy;

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt_inc_c;
    index_d     = index;
    spi_data_d  = spi_data;
    lcd_dc_d    = lcd_dc;
    init_done_d = init_done;

    case (state)
      RST_HOLD: if (hold_done_c) state_d = RST_WAIT;
      RST_WAIT: begin
        if (wait_done_c) begin
          state_d = INIT_SEND;
          index_d = 8'd0;
        end
      end
      INIT_SEND: state_d = INIT_WAIT;
      INIT_WAIT: begin
        if (xfer_done_c) begin
          if ((32'(index) + 32'd1) < INIT_LEN) begin
            state_d = INIT_SEND;
            index_d = index + 8'd1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          state_d    = SEND;
          spi_data_d = cmd_byte;
          lcd_dc_d   = cmd_dc;
        end
      end
      SEND: state_d = WAIT;
      WAIT: if (xfer_done_c) state_d = IDLE;
      default: state_d = RST_HOLD;
    endcase

    if (state_d != state) cnt_d = '0;

    if (state_d == INIT_SEND) begin
      spi_data_d = rom_entry_c.data;
      lcd_dc_d   = rom_entry_c.dc;
    end

    spi_start_d = (state_d == INIT_SEND) || (state_d == SEND);
    lcd_rst_n_d = (state_d != RST_HOLD);
    if (state_d == IDLE) init_done_d = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RST_HOLD;
      cnt       <= '0;
      index     <= '0;
      spi_start <= 1'b0;
      spi_data  <= '0;
      lcd_dc    <= 1'b0;
      lcd_rst_n <= 1'b0;
      init_done <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      index     <= index_d;
      spi_start <= spi_start_d;
      spi_data  <= spi_data_d;
      lcd_dc    <= lcd_dc_d;
      lcd_rst_n <= lcd_rst_n_d;
      init_done <= init_done_d;
    end
  end

endmodule
